// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_e   : fetch FSM state encoding
//   DefaultResetPc  : default first fetch address after reset
//   DefaultTimeout  : default number of S_WAIT cycles before the error trap
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;
  localparam int unsigned DefaultTimeout = 16;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-pc arithmetic for the fetch unit.
//   pc_i            : current fetch pc
//   instr_pc_i      : address of the held (consumed) instruction
//   jump_i          : consumed instruction is a jump
//   jump_target_i   : 26-bit jump field
//   branch_i        : consumed instruction is a taken branch
//   branch_offset_i : 16-bit signed word offset of the branch
//   pc_inc_o        : pc_i + 4, wrapping modulo 2^32
//   redirect_o      : a redirect is requested
//   redirect_pc_o   : redirect target, jump taking priority over branch
module fetch_next_pc (
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_pc_i,
  input  logic        jump_i,
  input  logic [25:0] jump_target_i,
  input  logic        branch_i,
  input  logic [15:0] branch_offset_i,
  output logic [31:0] pc_inc_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o
);

  logic [31:0] seq_pc;
  logic [31:0] branch_disp;
  logic [31:0] jump_pc;
  logic [31:0] branch_pc;

  always_comb begin
    pc_inc_o    = pc_i + 32'd4;
    // Both targets are relative to the instruction following the consumed one.
    seq_pc      = instr_pc_i + 32'd4;
    branch_disp = {{14{branch_offset_i[15]}}, branch_offset_i, 2'b00};
    jump_pc     = {seq_pc[31:28], jump_target_i, 2'b00};
    branch_pc   = seq_pc + branch_disp;

    redirect_o    = jump_i | branch_i;
    redirect_pc_o = jump_i ? jump_pc : branch_pc;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues single-outstanding fetch requests, holds each
// returned word for the decoder and redirects on jumps/taken branches.
//   clk, rst                      : clock, synchronous active-high reset
//   imem_req/imem_addr            : one-cycle fetch request and byte address
//   imem_rvalid/imem_rdata        : returned instruction word
//   instr_valid/instruction/instr_pc, instr_ready : decoder handshake
//   redirect_jump/jump_target     : jump redirect, sampled on handshake only
//   redirect_branch/branch_offset : branch redirect, sampled on handshake only
//   fetch_err                     : sticky memory-timeout flag
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc,
  parameter int unsigned TIMEOUT  = DefaultTimeout
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_jump,
  input  logic [25:0] jump_target,
  input  logic        redirect_branch,
  input  logic [15:0] branch_offset,
  output logic        fetch_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  ipc_q, ipc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] cnt_inc;
  logic         err_q, err_d;

  logic [31:0]  pc_inc;
  logic         redirect;
  logic [31:0]  redirect_pc;

  fetch_next_pc u_next_pc (
    .pc_i            (pc_q),
    .instr_pc_i      (ipc_q),
    .jump_i          (redirect_jump),
    .jump_target_i   (jump_target),
    .branch_i        (redirect_branch),
    .branch_offset_i (branch_offset),
    .pc_inc_o        (pc_inc),
    .redirect_o      (redirect),
    .redirect_pc_o   (redirect_pc)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    ipc_d       = ipc_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    cnt_inc     = cnt_q + CntW'(1);

    unique case (state_q)
      S_REQ: begin
        imem_req = 1'b1;
        cnt_d    = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          ipc_d   = pc_q;
          pc_d    = pc_inc;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntW'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
      end
      S_HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          // pc already points past the held word; only redirects change it.
          if (redirect) begin
            pc_d = redirect_pc;
          end
          state_d = S_REQ;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign instr_pc    = ipc_q;
  assign fetch_err   = err_q;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  RESET_PC, 32'h0000_0000, first fetch address after reset
  TIMEOUT, 16, maximum cycles spent in S_WAIT before the error trap
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
  clk  in  1  single clock; all state updates on rising edge
  rst  in  1  synchronous, active-high reset
  imem_req  out  1  one-cycle fetch request strobe
  imem_addr  out  32  fetch byte address; valid while imem_req=1
  imem_rvalid  in  1  instruction word returned
  imem_rdata  in  32  instruction word
  instr_valid  out  1  instruction held for the decoder
  instruction  out  32  held instruction word
  instr_pc  out  32  address of the held instruction
  instr_ready  in  1  decoder consumes the held instruction
  redirect_jump  in  1  consumed instruction is a jump
  jump_target  in  26  jump field, instruction[25:0]
  redirect_branch  in  1  consumed instruction is a taken branch
  branch_offset  in  16  branch field, instruction[15:0]
  fetch_err  out  1  sticky memory-timeout flag
REQ-003 Clock SHALL be clk; reset SHALL be rst, synchronous and active-high.

Function
REQ-004 The FSM SHALL have the states S_REQ, S_WAIT, S_HOLD and S_ERR.
REQ-005 In S_REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc; the next state SHALL be S_WAIT.
REQ-006 In S_WAIT with imem_rvalid=1, the block SHALL load instruction<=imem_rdata and instr_pc<=pc, set pc<=pc+4, and go to S_HOLD.
REQ-007 pc+4 SHALL wrap modulo 2^32: 32'hFFFF_FFFC SHALL advance to 32'h0000_0000.
REQ-008 instr_valid SHALL be 1 only in S_HOLD; instruction and instr_pc SHALL remain stable until a handshake occurs.
REQ-009 A handshake SHALL be instr_valid & instr_ready in S_HOLD; the next state SHALL then be S_REQ.
REQ-010 The block SHALL sample redirect_jump and redirect_branch only in a handshake cycle and SHALL ignore them at all other times.
REQ-011 On a handshake with redirect_jump=1, pc SHALL become {instr_pc+4 [31:28], jump_target, 2'b00}.
REQ-012 On a handshake with redirect_branch=1 and redirect_jump=0, pc SHALL become instr_pc+4+(sign-extended branch_offset<<2), computed modulo 2^32.
REQ-013 If redirect_jump and redirect_branch are both 1, the jump SHALL take priority.
REQ-014 imem_rvalid SHALL be ignored in S_REQ, S_HOLD and S_ERR; there SHALL be at most one outstanding request.
REQ-015 A wait counter SHALL clear on entry to S_WAIT and increment each cycle spent in S_WAIT without imem_rvalid.
REQ-016 When the wait counter reaches TIMEOUT, the FSM SHALL go to S_ERR and set fetch_err=1.
REQ-017 In S_ERR, imem_req and instr_valid SHALL be 0; the FSM SHALL remain in S_ERR until rst.
REQ-018 With zero-wait memory and instr_ready held at 1, instr_valid SHALL rise 2 cycles after the S_REQ cycle, and the block SHALL fetch one instruction every 3 cycles.

Reset
REQ-019 With rst=1 at a clock edge, the block SHALL set state=S_REQ, pc=RESET_PC, instruction=0, instr_pc=0, the wait counter to 0 and fetch_err=0.
REQ-020 After reset, imem_req=1 with imem_addr=RESET_PC SHALL appear in the first cycle after rst deasserts.
REQ-021 Reset asserted mid-operation, including in S_WAIT, SHALL abandon the outstanding request, and a late imem_rvalid SHALL be ignored.

Structure
REQ-022 A shared package fetch_pkg SHALL hold the state encoding, the default RESET_PC and the default TIMEOUT.
REQ-023 Next-pc arithmetic (pc+4, jump target, branch target, priority) SHALL be a combinational sub-module named fetch_next_pc.

Verification
REQ-024 Reset then zero-wait memory returning 32'h2002_0005 -> imem_addr=0; instr_valid with instruction=32'h2002_0005 and instr_pc=0; next fetch at 4.
REQ-025 Handshake at instr_pc=32'h0040_0010 with redirect_jump=1, jump_target=26'h000_0100 -> next imem_addr=32'h0000_0400.
REQ-026 Handshake at instr_pc=32'h0000_0020 with redirect_branch=1, branch_offset=16'hFFFE -> next imem_addr=32'h0000_001C; with both redirects set, the jump target is used.
REQ-027 instr_ready=0 for 5 cycles -> instruction stable, no imem_req, redirects ignored.
REQ-028 imem_rvalid withheld 16 cycles -> fetch_err=1, no further requests; rst -> recovery at RESET_PC.
REQ-029 pc=32'hFFFF_FFFC fetched -> next imem_addr=0; rst asserted in S_WAIT then a stale imem_rvalid -> ignored.
